// File: rtl/sig_add_pkg.sv
// sig_add_pkg: shared width helper and stage-1 record layout for the significand adder
`ifndef SIG_ADD_PKG_SV
`define SIG_ADD_PKG_SV
`define SIG_ADD_S1_T(W) struct packed { logic [W:0] presum; logic eff_sub; logic both_neg; logic largest_sign; }
package sig_add_pkg;
    function automatic int lzc_w(input int sig_w);
        return $clog2(sig_w + 2);
    endfunction
endpackage
`endif

// File: rtl/sig_lzc.sv
// sig_lzc: combinational leading-zero counter from the MSB; an all-zero input yields W
module sig_lzc #(
    parameter int W = 43
) (
    input  logic [W-1:0]             x,
    output logic [$clog2(W+1)-1:0]   cnt
);
    localparam int CW = $clog2(W + 1);
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) cnt = x[i] ? CW'(W - 1 - i) : cnt;
    end
endmodule

// File: rtl/sig_add_abs_pipe.sv
// sig_add_abs_pipe: two-stage multi-lane signed significand add/sub yielding magnitude, sign, zero flag and LZC
module sig_add_abs_pipe
    import sig_add_pkg::*;
#(
    parameter int SIG_W  = 42,
    parameter int LANES  = 1,
    parameter bit EN_LZC = 1
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic                                    DVI,
    output logic                                    IN_RDY,
    input  logic [LANES-1:0]                        LARGEST_SIGN,
    input  logic [LANES-1:0][1:0]                   OP_SIGNS,
    input  logic signed [LANES-1:0][1:0][SIG_W-1:0] SIGNIFICANDS,
    output logic                                    DVO,
    input  logic                                    OUT_RDY,
    output logic [LANES-1:0]                        SIGN,
    output logic [LANES-1:0]                        ZERO,
    output logic [LANES-1:0][SIG_W:0]               SUM_OF_SIGNIFICANDS,
    output logic [LANES-1:0][lzc_w(SIG_W)-1:0]      LZC
);
    localparam int LZC_W = lzc_w(SIG_W);
    typedef `SIG_ADD_S1_T(SIG_W) s1_t;

    s1_t [LANES-1:0]              s1_d, s1_q;
    logic [LANES-1:0]             sign_d, zero_d;
    logic [LANES-1:0][SIG_W:0]    mag_d;
    logic [LANES-1:0][LZC_W-1:0]  lz_d;
    logic                         v1, v2, adv1, adv2;

    assign adv2   = ~v2 | OUT_RDY;
    assign adv1   = ~v1 | adv2;
    assign IN_RDY = adv1;
    assign DVO    = v2;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [SIG_W:0] a, b;
        assign a = {SIGNIFICANDS[l][0][SIG_W-1], SIGNIFICANDS[l][0]};
        assign b = {SIGNIFICANDS[l][1][SIG_W-1], SIGNIFICANDS[l][1]};
        assign s1_d[l] = '{
            presum:       (OP_SIGNS[l][0] ^ OP_SIGNS[l][1]) ? a - b : a + b,
            eff_sub:      OP_SIGNS[l][0] ^ OP_SIGNS[l][1],
            both_neg:     OP_SIGNS[l][0] & OP_SIGNS[l][1],
            largest_sign: LARGEST_SIGN[l]
        };
        // -(-2^SIG_W) wraps to the same bit pattern, which reads correctly as unsigned
        assign mag_d[l]  = s1_q[l].presum[SIG_W] ? -s1_q[l].presum : s1_q[l].presum;
        assign zero_d[l] = ~|s1_q[l].presum;
        assign sign_d[l] = zero_d[l] ? ~s1_q[l].eff_sub & s1_q[l].both_neg
                                     : s1_q[l].presum[SIG_W] ^ s1_q[l].largest_sign;
        if (EN_LZC) begin : g_lzc
            sig_lzc #(.W(SIG_W + 1)) u_lzc (.x(mag_d[l]), .cnt(lz_d[l]));
        end else begin : g_nolzc
            assign lz_d[l] = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            v1                  <= 1'b0;
            v2                  <= 1'b0;
            s1_q                <= '0;
            SIGN                <= '0;
            ZERO                <= '0;
            SUM_OF_SIGNIFICANDS <= '0;
            LZC                 <= '0;
        end else begin
            if (adv1) v1 <= DVI;
            if (adv2) v2 <= v1;
            if (adv1 && DVI) s1_q <= s1_d;
            if (adv2 && v1) begin
                SIGN                <= sign_d;
                ZERO                <= zero_d;
                SUM_OF_SIGNIFICANDS <= mag_d;
                LZC                 <= lz_d;
            end
        end
    end
endmodule

// File: tb/tb_sig_add_abs_pipe.sv
// tb_sig_add_abs_pipe: directed scoreboard bench for the pipelined significand adder
module tb_sig_add_abs_pipe;
    typedef struct packed {
        logic [42:0] sum;
        logic        sign;
        logic        zero;
        logic [5:0]  lzc;
    } exp_t;

    logic clk = 1'b0;
    logic rst, dvi, in_rdy, dvo, out_rdy;
    logic [0:0]             ls, sign, zero;
    logic [0:0][1:0]        os;
    logic [0:0][1:0][41:0]  sg;
    logic [0:0][42:0]       sum;
    logic [0:0][5:0]        lzc;

    logic dvi4, in_rdy4, dvo4, out_rdy4;
    logic [3:0]             ls4, sign4, zero4;
    logic [3:0][1:0]        os4;
    logic [3:0][1:0][41:0]  sg4;
    logic [3:0][42:0]       sum4;
    logic [3:0][5:0]        lzc4;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    sig_add_abs_pipe #(.SIG_W(42), .LANES(1), .EN_LZC(1)) u_dut (
        .CLK(clk), .RST(rst), .DVI(dvi), .IN_RDY(in_rdy),
        .LARGEST_SIGN(ls), .OP_SIGNS(os), .SIGNIFICANDS(sg),
        .DVO(dvo), .OUT_RDY(out_rdy), .SIGN(sign), .ZERO(zero),
        .SUM_OF_SIGNIFICANDS(sum), .LZC(lzc)
    );

    sig_add_abs_pipe #(.SIG_W(42), .LANES(4), .EN_LZC(1)) u_dut4 (
        .CLK(clk), .RST(rst), .DVI(dvi4), .IN_RDY(in_rdy4),
        .LARGEST_SIGN(ls4), .OP_SIGNS(os4), .SIGNIFICANDS(sg4),
        .DVO(dvo4), .OUT_RDY(out_rdy4), .SIGN(sign4), .ZERO(zero4),
        .SUM_OF_SIGNIFICANDS(sum4), .LZC(lzc4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [41:0] s0, input logic [41:0] s1,
                                   input logic [1:0] ops, input logic lsg);
        longint a, b, r;
        int     n;
        exp_t   x;
        a = longint'($signed(s0));
        b = longint'($signed(s1));
        r = (ops[0] != ops[1]) ? a - b : a + b;
        x.zero = (r == 0);
        x.sum  = 43'(r < 0 ? -r : r);
        x.sign = x.zero ? (ops == 2'b11) : ((r < 0) != lsg);
        n = 0;
        while (n < 43 && !x.sum[42 - n]) n++;
        x.lzc = 6'(n);
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [41:0] s0, input logic [41:0] s1,
                        input logic [1:0] ops, input logic lsg);
        bit acc;
        int t;
        sg[0][0] = s0; sg[0][1] = s1; os[0] = ops; ls[0] = lsg; dvi = 1'b1;
        acc = 1'b0;
        t = 0;
        while (!acc && t < 20) begin
            @(negedge clk);
            acc = in_rdy;
            step();
            t++;
        end
        if (!acc) check("send_timeout", in_rdy, 1'b1);
        dvi = 1'b0;
    endtask

    task automatic wait_empty();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        check("drain", sb.size(), 0);
    endtask

    // Scoreboard: sampled mid-cycle, pop before push so an empty queue is caught
    always @(negedge clk) begin
        if (rst) sb.delete();
        else begin
            if (dvo && out_rdy) begin
                if (sb.size() == 0) check("unexpected_dvo", dvo, 1'b0);
                else begin
                    e = sb.pop_front();
                    check("sb_sum", sum[0], e.sum);
                    check("sb_sign", sign[0], e.sign);
                    check("sb_zero", zero[0], e.zero);
                    check("sb_lzc", lzc[0], e.lzc);
                end
            end
            if (dvi && in_rdy) sb.push_back(model(sg[0][0], sg[0][1], os[0], ls[0]));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [41:0] ts0[4] = '{42'd5, 42'd3, 42'd7, 42'd0};
        logic [41:0] ts1[4] = '{42'd3, 42'd5, 42'd7, 42'd0};
        logic [1:0]  tos[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic        tls[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        exp_t        e4;
        int          cnt;
        rst = 1'b1; dvi = 1'b0; out_rdy = 1'b1; ls = '0; os = '0; sg = '0;
        dvi4 = 1'b0; out_rdy4 = 1'b1; ls4 = '0; os4 = '0; sg4 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_dvo", dvo, 1'b0);
        check("rst_in_rdy", in_rdy, 1'b1);
        check("rst_sum", sum[0], 0);
        check("rst_sign", sign[0], 1'b0);
        check("rst_zero", zero[0], 1'b0);
        check("rst_lzc", lzc[0], 0);

        step();
        send(42'd5, 42'd3, 2'b00, 1'b0);
        @(negedge clk);
        check("lat_dvo_early", dvo, 1'b0);
        @(negedge clk);
        check("lat_dvo", dvo, 1'b1);
        check("add_sum", sum[0], 8);
        check("add_sign", sign[0], 1'b0);
        check("add_zero", zero[0], 1'b0);
        check("add_lzc", lzc[0], 39);

        step();
        send(42'd3, 42'd5, 2'b01, 1'b1);
        send(42'd7, 42'd7, 2'b10, 1'b0);
        send(42'd0, 42'd0, 2'b11, 1'b0);
        send(42'h200_0000_0000, 42'h1FF_FFFF_FFFF, 2'b01, 1'b1);
        send(42'h200_0000_0000, 42'h200_0000_0000, 2'b00, 1'b0);
        wait_empty();

        step();
        out_rdy = 1'b0;
        fork
            begin
                send(42'd100, 42'd27, 2'b00, 1'b0);
                send(42'd1000, 42'd1, 2'b01, 1'b0);
                send(42'd5, 42'd9, 2'b10, 1'b1);
                send(42'h3FF_FFFF_FFFF, 42'h3FF_FFFF_FFFF, 2'b11, 1'b1);
            end
            begin
                repeat (3) @(negedge clk);
                check("bp_in_rdy_low", in_rdy, 1'b0);
                check("bp_dvo", dvo, 1'b1);
                check("bp_hold_sum", sum[0], 127);
                check("bp_hold_lzc", lzc[0], 36);
                @(posedge clk);
                @(negedge clk);
                check("bp_stall_dvo", dvo, 1'b1);
                check("bp_stall_sum", sum[0], 127);
                check("bp_stall_lzc", lzc[0], 36);
                step();
                out_rdy = 1'b1;
                cnt = 0;
                repeat (4) begin
                    @(negedge clk);
                    if (dvo) cnt++;
                end
                check("bp_burst", cnt, 4);
            end
        join
        wait_empty();

        step();
        out_rdy = 1'b0;
        send(42'd11, 42'd4, 2'b00, 1'b0);
        send(42'd20, 42'd3, 2'b00, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_dvo", dvo, 1'b0);
        check("mid_rst_in_rdy", in_rdy, 1'b1);
        check("mid_rst_sum", sum[0], 0);
        check("mid_rst_sign", sign[0], 1'b0);
        check("mid_rst_zero", zero[0], 1'b0);
        check("mid_rst_lzc", lzc[0], 0);
        step();
        out_rdy = 1'b1;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (dvo) cnt++;
        end
        check("mid_rst_no_out", cnt, 0);

        step();
        for (int l = 0; l < 4; l++) begin
            sg4[l][0] = ts0[l]; sg4[l][1] = ts1[l]; os4[l] = tos[l]; ls4[l] = tls[l];
        end
        dvi4 = 1'b1;
        @(negedge clk);
        check("l4_in_rdy", in_rdy4, 1'b1);
        step();
        dvi4 = 1'b0;
        @(negedge clk);
        check("l4_dvo_early", dvo4, 1'b0);
        @(negedge clk);
        check("l4_dvo", dvo4, 1'b1);
        for (int l = 0; l < 4; l++) begin
            e4 = model(ts0[l], ts1[l], tos[l], tls[l]);
            check($sformatf("l4_lane%0d_sum", l), sum4[l], e4.sum);
            check($sformatf("l4_lane%0d_sign", l), sign4[l], e4.sign);
            check($sformatf("l4_lane%0d_zero", l), zero4[l], e4.zero);
            check($sformatf("l4_lane%0d_lzc", l), lzc4[l], e4.lzc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
